main_mem_ctrl: RTL and testbench
================================

Name: main_mem_ctrl

Overview:
- Backing-store controller directly downstream of the cache controller; consumes its RAMreadEnable/RAMwriteEnable strobes and produces dataReady plus line data.
- Holds a 2^addrSize x ramWidth word array that models slow main memory with fixed, parameterised read and write latencies.
- One-entry posted write buffer, so a single-cycle write strobe (dirty-line writeback) completes immediately from the cache side; a following read stalls only as needed.

Parameters:
- ramWidth, 8, data word width in bits.
- addrSize, 8, address width; the array depth is 2^addrSize.
- readLatency, 3, cycles from read acceptance to the dataReady pulse; legal range 1..15.
- writeLatency, 2, cycles a posted write occupies the array before committing; legal range 1..15.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- readEnable  input  1  read request, level; held high until dataReady is seen.
- writeEnable  input  1  write request, single-cycle strobe.
- addr  input  addrSize  word address, sampled on acceptance.
- writeData  input  ramWidth  write data, sampled with writeEnable.
- readData  output  ramWidth  read result; valid with dataReady and held until the next read completes.
- dataReady  output  1  one-cycle pulse marking read completion.
- busy  output  1  high while the write buffer is occupied or a read is in flight.
- writeDropped  output  1  sticky flag set when a write arrives while the buffer is full; cleared only by reset.

Behaviour:
- Reset (async, rst_n=0): state IDLE; readData=0, dataReady=0, busy=0, writeDropped=0; write buffer invalid; counters 0. The array is not cleared. An in-flight read or an uncommitted write is abandoned.
- Write buffer: fields wbValid, wbAddr, wbData, wbCount.
  - A writeEnable with wbValid=0 loads the buffer that edge and sets wbCount=writeLatency.
  - wbCount decrements each cycle. At wbCount reaching 1, the next edge writes the array and clears wbValid. The write is independent of the read FSM.
  - A writeEnable with wbValid=1 is ignored and sets writeDropped.
- Read FSM states:
  - IDLE: if readEnable=1 and writeEnable=0, latch addr into rdAddr and go to WAIT_WB if wbValid=1, else to READ with rdCount=readLatency.
  - WAIT_WB: stay until wbValid=0, then go to READ with rdCount=readLatency.
  - READ: decrement rdCount. At rdCount=1, next edge loads readData=mem[rdAddr], sets dataReady=1, and goes to DONE.
  - DONE: dataReady=1 for exactly this cycle. Go to IDLE if readEnable=0, else to HOLD.
  - HOLD: wait for readEnable=0, then go to IDLE. This prevents a held request from starting a second read.
- Simultaneous readEnable and writeEnable in IDLE: the write is captured first; the read is accepted the next cycle (write-before-read ordering).
- Total read latency is counted from the accepting edge.
  - Buffer empty: dataReady rises exactly readLatency cycles after acceptance.
  - Buffer occupied: add the remaining wbCount cycles.
- Same-address hazard: no forwarding. The WAIT_WB stall guarantees the read returns the just-written value.
- busy = wbValid OR (state != IDLE).
- readData changes only on DONE entry.
- Address wrap: addr is used modulo 2^addrSize; no bounds error.

Decomposition:
- Shared package holds:
  - read FSM state encodings (one-hot, 5 bits: IDLE, WAIT_WB, READ, DONE, HOLD);
  - latency counter width constant (4 bits);
  - default ramWidth and addrSize.
- One sub-module is natural: mem_write_buffer (holds wbValid, wbAddr, wbData, wbCount; outputs the commit strobe, commit address and commit data). The FSM and array stay in main_mem_ctrl.

Test Plan:
- Reset mid-read: assert readEnable at addr 0x10, pull rst_n low during READ -> all outputs 0 immediately; no dataReady after release.
- Basic read after write, default latencies: write 0xA5 to 0x3C, then idle 3 cycles; hold readEnable at 0x3C -> dataReady exactly 3 cycles after acceptance, readData=0xA5 for one cycle, then FSM returns to IDLE once readEnable drops.
- Writeback then fetch (cache miss pattern): writeEnable strobe at 0x20 with 0x11, readEnable at 0x20 the next cycle -> WAIT_WB for 1 cycle, dataReady 4 cycles after the read request, readData=0x11.
- Held request: keep readEnable high 5 cycles past dataReady -> exactly one dataReady pulse, FSM in HOLD, busy=1 until readEnable drops.
- Buffer overflow: two consecutive writeEnable strobes (0x01<-0x55, 0x02<-0x66) -> writeDropped=1; reading 0x01 returns 0x55; 0x02 retains its prior value.
- Simultaneous strobes: writeEnable and readEnable both high at addr 0xFF, writeData 0x7E -> read accepted the cycle after, readData=0x7E.

Source files
------------

// File: rtl/main_mem_ctrl_pkg.sv
// Shared types and constants for the main memory controller.
package main_mem_ctrl_pkg;

  localparam int CNT_W         = 4;
  localparam int DEF_RAM_WIDTH = 8;
  localparam int DEF_ADDR_SIZE = 8;

  typedef logic [CNT_W-1:0] lat_cnt_t;

  typedef enum logic [4:0] {
    ST_IDLE    = 5'b00001,
    ST_WAIT_WB = 5'b00010,
    ST_READ    = 5'b00100,
    ST_DONE    = 5'b01000,
    ST_HOLD    = 5'b10000
  } rd_state_e;

endpackage

// File: rtl/main_mem_ctrl_if.sv
// Cache-side request/response bundle of the main memory controller.
interface main_mem_ctrl_if import main_mem_ctrl_pkg::*; #(
  parameter int ramWidth = DEF_RAM_WIDTH,
  parameter int addrSize = DEF_ADDR_SIZE
) ();
  logic                readEnable;
  logic                writeEnable;
  logic [addrSize-1:0] addr;
  logic [ramWidth-1:0] writeData;
  logic [ramWidth-1:0] readData;
  logic                dataReady;
  logic                busy;
  logic                writeDropped;

  modport master (
    output readEnable, writeEnable, addr, writeData,
    input  readData, dataReady, busy, writeDropped
  );

  modport slave (
    input  readEnable, writeEnable, addr, writeData,
    output readData, dataReady, busy, writeDropped
  );
endinterface

// File: rtl/main_mem_ctrl_write_buffer.sv
// One-entry posted write buffer; holds a write for writeLatency cycles, then commits it.
module mem_write_buffer import main_mem_ctrl_pkg::*; #(
  parameter int ramWidth     = DEF_RAM_WIDTH,
  parameter int addrSize     = DEF_ADDR_SIZE,
  parameter int writeLatency = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                wr_en,
  input  logic [addrSize-1:0] wr_addr,
  input  logic [ramWidth-1:0] wr_data,
  output logic                wb_valid,
  output logic                commit,
  output logic [addrSize-1:0] commit_addr,
  output logic [ramWidth-1:0] commit_data,
  output logic                dropped
);
  lat_cnt_t wb_count;

  assign commit = wb_valid && (wb_count == lat_cnt_t'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wb_valid    <= 1'b0;
      wb_count    <= '0;
      commit_addr <= '0;
      commit_data <= '0;
      dropped     <= 1'b0;
    end else if (wb_valid) begin
      // Buffer full: a new write is lost and flagged until reset.
      if (wr_en)  dropped  <= 1'b1;
      if (commit) wb_valid <= 1'b0;
      wb_count <= wb_count - 1'b1;
    end else if (wr_en) begin
      wb_valid    <= 1'b1;
      wb_count    <= lat_cnt_t'(writeLatency);
      commit_addr <= wr_addr;
      commit_data <= wr_data;
    end
  end
endmodule

// File: rtl/main_mem_ctrl.sv
// Slow main-memory model: word array, posted write buffer and latency-counted read FSM.
module main_mem_ctrl import main_mem_ctrl_pkg::*; #(
  parameter int ramWidth     = DEF_RAM_WIDTH,
  parameter int addrSize     = DEF_ADDR_SIZE,
  parameter int readLatency  = 3,
  parameter int writeLatency = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  main_mem_ctrl_if.slave    bus
);
  logic [ramWidth-1:0] mem [0:(1<<addrSize)-1];

  logic                wb_valid, wb_commit, wb_dropped;
  logic [addrSize-1:0] commit_addr;
  logic [ramWidth-1:0] commit_data;

  rd_state_e           state, state_n;
  lat_cnt_t            rd_count, rd_count_n;
  logic [addrSize-1:0] rd_addr, rd_addr_n;
  logic [ramWidth-1:0] rd_data;
  logic                load_data;

  mem_write_buffer #(
    .ramWidth(ramWidth), .addrSize(addrSize), .writeLatency(writeLatency)
  ) u_wbuf (
    .clk(clk), .rst_n(rst_n),
    .wr_en(bus.writeEnable), .wr_addr(bus.addr), .wr_data(bus.writeData),
    .wb_valid(wb_valid), .commit(wb_commit),
    .commit_addr(commit_addr), .commit_data(commit_data),
    .dropped(wb_dropped)
  );

  always_ff @(posedge clk) begin
    if (wb_commit) mem[commit_addr] <= commit_data;
  end

  // A buffer committing on this edge is already empty as far as a waiting read is concerned.
  always_comb begin
    state_n    = state;
    rd_count_n = rd_count;
    rd_addr_n  = rd_addr;
    load_data  = 1'b0;
    case (state)
      ST_IDLE: if (bus.readEnable && !bus.writeEnable) begin
        rd_addr_n = bus.addr;
        if (wb_valid && !wb_commit) state_n = ST_WAIT_WB;
        else begin
          state_n    = ST_READ;
          rd_count_n = lat_cnt_t'(readLatency);
        end
      end
      ST_WAIT_WB: if (!wb_valid || wb_commit) begin
        state_n    = ST_READ;
        rd_count_n = lat_cnt_t'(readLatency);
      end
      ST_READ: begin
        rd_count_n = rd_count - 1'b1;
        if (rd_count == lat_cnt_t'(1)) begin
          state_n   = ST_DONE;
          load_data = 1'b1;
        end
      end
      ST_DONE: state_n = bus.readEnable ? ST_HOLD : ST_IDLE;
      ST_HOLD: if (!bus.readEnable) state_n = ST_IDLE;
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      rd_count <= '0;
      rd_addr  <= '0;
      rd_data  <= '0;
    end else begin
      state    <= state_n;
      rd_count <= rd_count_n;
      rd_addr  <= rd_addr_n;
      if (load_data) rd_data <= mem[rd_addr];
    end
  end

  assign bus.readData     = rd_data;
  assign bus.dataReady    = (state == ST_DONE);
  assign bus.busy         = wb_valid || (state != ST_IDLE);
  assign bus.writeDropped = wb_dropped;
endmodule

// File: tb/tb_main_mem_ctrl.sv
// Directed bench for main_mem_ctrl with a read-data scoreboard and latency checks.
module tb_main_mem_ctrl;
  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;
  int   cnt    = 0;
  int   pulses = 0;
  logic [7:0] model [256];
  logic [7:0] sb_q [$];

  main_mem_ctrl_if #(.ramWidth(8), .addrSize(8)) bus ();

  main_mem_ctrl #(
    .ramWidth(8), .addrSize(8), .readLatency(3), .writeLatency(2)
  ) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  always #5 clk = ~clk;
  always @(posedge clk) cnt <= cnt + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard drain: every dataReady pulse must match the oldest pending read.
  always @(negedge clk) begin
    if (rst_n && bus.dataReady) begin
      pulses++;
      if (sb_q.size() == 0) chk("ready_without_request", 32'(bus.dataReady), 32'd0);
      else chk("read_data", 32'(bus.readData), 32'(sb_q.pop_front()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic write(input logic [7:0] a, input logic [7:0] d, input bit drop);
    bus.addr        = a;
    bus.writeData   = d;
    bus.writeEnable = 1'b1;
    if (!drop) model[a] = d;
    cyc();
    bus.writeEnable = 1'b0;
  endtask

  task automatic wait_done(input int req, input int exp_lat, input int hold, input string tag);
    int found_at;
    found_at = -1;
    for (int i = 0; i < 40; i++) begin
      if (bus.dataReady) begin
        found_at = cnt;
        break;
      end
      cyc();
    end
    chk({tag, "_ready"}, 32'(bus.dataReady), 32'd1);
    if (found_at >= 0) chk({tag, "_latency"}, 32'(found_at - (req + 1)), 32'(exp_lat));
    for (int i = 0; i < hold; i++) begin
      cyc();
      chk({tag, "_hold_busy"}, 32'(bus.busy), 32'd1);
      chk({tag, "_hold_noready"}, 32'(bus.dataReady), 32'd0);
    end
    bus.readEnable = 1'b0;
    cyc();
    chk({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  task automatic do_read(input logic [7:0] a, input int exp_lat, input int hold, input string tag);
    int req;
    bus.readEnable = 1'b1;
    bus.addr       = a;
    sb_q.push_back(model[a]);
    req = cnt;
    cyc();
    wait_done(req, exp_lat, hold, tag);
  endtask

  initial begin
    int p0, req;
    rst_n           = 1'b0;
    bus.readEnable  = 1'b0;
    bus.writeEnable = 1'b0;
    bus.addr        = '0;
    bus.writeData   = '0;
    idle(2);
    chk("rst_read_data", 32'(bus.readData), 32'd0);
    chk("rst_ready", 32'(bus.dataReady), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_dropped", 32'(bus.writeDropped), 32'd0);
    rst_n = 1'b1;
    cyc();

    write(8'h02, 8'h33, 1'b0);
    idle(3);
    write(8'h3C, 8'hA5, 1'b0);
    chk("wb_busy", 32'(bus.busy), 32'd1);
    idle(3);
    chk("wb_drained", 32'(bus.busy), 32'd0);
    do_read(8'h3C, 3, 0, "basic");

    // Reset in the middle of a read must abandon it.
    bus.readEnable = 1'b1;
    bus.addr       = 8'h10;
    cyc();
    cyc();
    chk("midread_busy", 32'(bus.busy), 32'd1);
    rst_n = 1'b0;
    #1;
    chk("midrst_read_data", 32'(bus.readData), 32'd0);
    chk("midrst_ready", 32'(bus.dataReady), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_dropped", 32'(bus.writeDropped), 32'd0);
    bus.readEnable = 1'b0;
    cyc();
    rst_n = 1'b1;
    p0 = pulses;
    idle(6);
    chk("midrst_no_pulse", 32'(pulses), 32'(p0));

    write(8'h20, 8'h11, 1'b0);
    do_read(8'h20, 4, 0, "wb_fetch");

    p0 = pulses;
    do_read(8'h3C, 3, 5, "held");
    chk("held_one_pulse", 32'(pulses), 32'(p0 + 1));

    chk("ovf_pre_dropped", 32'(bus.writeDropped), 32'd0);
    write(8'h01, 8'h55, 1'b0);
    write(8'h02, 8'h66, 1'b1);
    chk("ovf_dropped", 32'(bus.writeDropped), 32'd1);
    idle(3);
    do_read(8'h01, 3, 0, "ovf_rd01");
    do_read(8'h02, 3, 0, "ovf_rd02");
    chk("ovf_sticky", 32'(bus.writeDropped), 32'd1);

    bus.addr        = 8'hFF;
    bus.writeData   = 8'h7E;
    bus.writeEnable = 1'b1;
    bus.readEnable  = 1'b1;
    model[8'hFF]    = 8'h7E;
    sb_q.push_back(8'h7E);
    req = cnt;
    cyc();
    bus.writeEnable = 1'b0;
    wait_done(req, 5, 0, "simul");

    idle(2);
    chk("sb_drained", 32'(sb_q.size()), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
